// File: rtl/vga_pkg.sv
// Shared types and defaults for the vga line feeder: pixel colour, writer
// FSM states and the output-select code carried alongside each read.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned COLOR_W  = 12;

    typedef logic [COLOR_W-1:0] color_t;

    localparam color_t BG_COLOR = 12'h000;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } wr_state_e;

    typedef enum logic [1:0] {
        SEL_BLANK = 2'd0,
        SEL_BG    = 2'd1,
        SEL_PIX   = 2'd2
    } out_sel_e;

endpackage

// File: rtl/vga_line_ram.sv
// Simple dual-port line RAM: one write port, one registered read port.
// Address is {bank, pixel}, so the two line banks occupy the two halves.
module vga_line_ram #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 12
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [2**AW];

    // No reset on storage or read register so the array maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/vga_line_feeder.sv
// Ping-pong line buffer feeding the vga colour input: a renderer fills one bank
// while the other is replayed, banks swap on next_line when the fill is complete.
module vga_line_feeder #(
    parameter int unsigned          H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int unsigned          COLOR_W  = vga_pkg::COLOR_W,
    parameter logic [COLOR_W-1:0]   BG_COLOR = vga_pkg::BG_COLOR
) (
    input  logic               CLK25MHZ,
    input  logic               ck_rst,
    input  logic [COLOR_W-1:0] wr_data,
    input  logic               wr_valid,
    input  logic               wr_last,
    output logic               wr_ready,
    input  logic               next_line,
    input  logic               pix_active,
    output logic [COLOR_W-1:0] color_out,
    output logic               line_ready,
    output logic               underrun,
    output logic [7:0]         underrun_cnt
);

    import vga_pkg::*;

    localparam int unsigned AW = $clog2(H_ACTIVE);
    localparam int unsigned LW = AW + 1;

    typedef logic [AW-1:0] addr_t;
    typedef logic [LW-1:0] len_t;

    localparam addr_t ADDR_MAX = addr_t'(H_ACTIVE - 1);

    wr_state_e           state_q, state_d;
    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic [1:0][LW-1:0]  len_q, len_d;
    addr_t               wr_addr_q, wr_addr_d;
    addr_t               rd_addr_q, rd_addr_d;
    out_sel_e            sel_q, sel_d;
    logic                underrun_q, underrun_d;
    logic [7:0]          ucnt_q, ucnt_d;
    logic [COLOR_W-1:0]  ram_rdata;
    logic                wr_fire, last_beat, full_next;

    assign wr_fire   = wr_valid && wr_ready;
    assign last_beat = wr_fire && (wr_last || (wr_addr_q == ADDR_MAX));
    // A beat completing on the same edge as next_line still earns the swap.
    assign full_next = (state_q == FULL) || last_beat;

    always_ff @(posedge CLK25MHZ or negedge ck_rst) begin
        if (!ck_rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (last_beat && !next_line) state_d = FULL;
            FULL:    if (next_line) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        wr_ready   = 1'b0;
        line_ready = 1'b0;
        case (state_q)
            FILL:    wr_ready = ck_rst;
            FULL:    line_ready = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        len_d      = len_q;
        wr_addr_d  = wr_addr_q;
        underrun_d = 1'b0;
        ucnt_d     = ucnt_q;
        if (wr_fire) begin
            if (last_beat) begin
                len_d[wr_bank_q] = len_t'(wr_addr_q) + len_t'(1);
            end else begin
                wr_addr_d = wr_addr_q + addr_t'(1);
            end
        end
        if (next_line) begin
            if (full_next) begin
                rd_bank_d         = wr_bank_q;
                wr_bank_d         = ~wr_bank_q;
                len_d[~wr_bank_q] = '0;
                wr_addr_d         = '0;
            end else begin
                // Blank the line being shown; the writer keeps its partial fill.
                len_d[rd_bank_q] = '0;
                underrun_d       = 1'b1;
                if (ucnt_q != 8'hFF) begin
                    ucnt_d = ucnt_q + 8'd1;
                end
            end
        end
    end

    always_comb begin
        rd_addr_d = rd_addr_q;
        sel_d     = SEL_BLANK;
        if (pix_active) begin
            sel_d = (len_t'(rd_addr_q) >= len_q[rd_bank_q]) ? SEL_BG : SEL_PIX;
            if (rd_addr_q != ADDR_MAX) begin
                rd_addr_d = rd_addr_q + addr_t'(1);
            end
        end
        if (next_line) begin
            rd_addr_d = '0;
        end
    end

    always_ff @(posedge CLK25MHZ or negedge ck_rst) begin
        if (!ck_rst) begin
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b1;
            len_q      <= '0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            sel_q      <= SEL_BLANK;
            underrun_q <= 1'b0;
            ucnt_q     <= '0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            len_q      <= len_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            sel_q      <= sel_d;
            underrun_q <= underrun_d;
            ucnt_q     <= ucnt_d;
        end
    end

    vga_line_ram #(
        .AW (AW + 1),
        .DW (COLOR_W)
    ) u_ram (
        .clk_i   (CLK25MHZ),
        .we_i    (wr_fire),
        .waddr_i ({wr_bank_q, wr_addr_q}),
        .wdata_i (wr_data),
        .re_i    (pix_active),
        .raddr_i ({rd_bank_q, rd_addr_q}),
        .rdata_o (ram_rdata)
    );

    // The select code is registered with the RAM read, so this mux adds no latency.
    always_comb begin
        color_out = '0;
        case (sel_q)
            SEL_BG:  color_out = BG_COLOR;
            SEL_PIX: color_out = ram_rdata;
            default: color_out = '0;
        endcase
    end

    assign underrun     = underrun_q;
    assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_vga_line_feeder.sv
// Directed bench for vga_line_feeder with an 8-pixel line: expected pixels are
// queued as pix_active is driven and a monitor compares them one cycle later.
`timescale 1ns/100ps
module tb_vga_line_feeder;

    localparam int unsigned H  = 8;
    localparam logic [11:0] BG = 12'h5A5;

    logic        clk = 1'b1;
    logic        ck_rst;
    logic [11:0] wr_data;
    logic        wr_valid;
    logic        wr_last;
    logic        wr_ready;
    logic        next_line;
    logic        pix_active;
    logic [11:0] color_out;
    logic        line_ready;
    logic        underrun;
    logic [7:0]  underrun_cnt;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];
    logic        pa_d = 1'b0;

    always #1 clk = ~clk;

    vga_line_feeder #(
        .H_ACTIVE (H),
        .COLOR_W  (12),
        .BG_COLOR (BG)
    ) dut (
        .CLK25MHZ     (clk),
        .ck_rst       (ck_rst),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_last      (wr_last),
        .wr_ready     (wr_ready),
        .next_line    (next_line),
        .pix_active   (pix_active),
        .color_out    (color_out),
        .line_ready   (line_ready),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always @(posedge clk) pa_d <= pix_active && ck_rst;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle either a queued pixel or blanking (zero) is due.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (pa_d) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pix_noexp actual=%0h expected=none", color_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel", int'(color_out), int'(e));
                end
            end else begin
                chk("blank", int'(color_out), 0);
            end
        end
    end

    task automatic idle(input int n);
        wr_valid = 1'b0; wr_last = 1'b0; next_line = 1'b0; pix_active = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic write_beat(input logic [11:0] d, input logic last, input logic nl);
        int n;
        n = 0;
        wr_data = d; wr_valid = 1'b1; wr_last = last; next_line = nl;
        while (!wr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wr_ready_wait", int'(wr_ready), 1);
        @(negedge clk);
        wr_valid = 1'b0; wr_last = 1'b0; next_line = 1'b0;
    endtask

    task automatic pulse_nl();
        next_line = 1'b1;
        @(negedge clk);
        next_line = 1'b0;
    endtask

    task automatic pix(input logic [11:0] e);
        pix_active = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ck_rst = 1'b0; wr_data = '0; wr_valid = 1'b0; wr_last = 1'b0;
        next_line = 1'b0; pix_active = 1'b0;
        #3;
        chk("rst_wr_ready", int'(wr_ready), 0);
        ck_rst = 1'b1;
        #0.1;
        chk("rel_wr_ready", int'(wr_ready), 1);
        @(negedge clk);
        chk("rst_line_ready", int'(line_ready), 0);
        chk("rst_ucnt", int'(underrun_cnt), 0);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_color", int'(color_out), 0);

        // Full line 001..008
        for (int i = 1; i <= 8; i++) write_beat(12'(i), (i == 8), 1'b0);
        chk("t2_line_ready", int'(line_ready), 1);
        chk("t2_wr_ready_full", int'(wr_ready), 0);
        pulse_nl();
        chk("t2_line_ready_swap", int'(line_ready), 0);
        chk("t2_wr_ready_swap", int'(wr_ready), 1);
        chk("t2_no_underrun", int'(underrun), 0);
        for (int i = 1; i <= 8; i++) pix(12'(i));
        idle(2);

        // Short line with early wr_last
        for (int i = 0; i < 3; i++) write_beat(12'hF00, (i == 2), 1'b0);
        chk("t3_line_ready", int'(line_ready), 1);
        pulse_nl();
        for (int i = 0; i < 8; i++) pix((i < 3) ? 12'hF00 : BG);
        idle(2);

        // Underrun: half a line, then next_line
        for (int i = 0; i < 4; i++) write_beat(12'h010 + 12'(i), 1'b0, 1'b0);
        chk("t4_line_ready", int'(line_ready), 0);
        pulse_nl();
        chk("t4_underrun", int'(underrun), 1);
        chk("t4_ucnt", int'(underrun_cnt), 1);
        chk("t4_wr_ready", int'(wr_ready), 1);
        @(negedge clk);
        chk("t4_underrun_pulse", int'(underrun), 0);
        for (int i = 0; i < 8; i++) pix(BG);
        idle(1);
        for (int i = 4; i < 8; i++) write_beat(12'h010 + 12'(i), 1'b0, 1'b0);
        chk("t4_line_ready_full", int'(line_ready), 1);
        pulse_nl();
        for (int i = 0; i < 8; i++) pix(12'h010 + 12'(i));
        idle(2);

        // Final beat coincides with next_line
        for (int i = 0; i < 7; i++) write_beat(12'h020 + 12'(i), 1'b0, 1'b0);
        write_beat(12'h027, 1'b1, 1'b1);
        chk("t5_no_underrun", int'(underrun), 0);
        chk("t5_ucnt", int'(underrun_cnt), 1);
        chk("t5_line_ready", int'(line_ready), 0);
        chk("t5_wr_ready", int'(wr_ready), 1);
        for (int i = 0; i < 8; i++) pix(12'h020 + 12'(i));
        idle(2);

        // Reset in the middle of a replay
        for (int i = 0; i < 3; i++) write_beat(12'h030 + 12'(i), (i == 2), 1'b0);
        pulse_nl();
        pix(12'h030);
        pix(12'h031);
        pix_active = 1'b0;
        #0.5;
        ck_rst = 1'b0;
        #0.1;
        chk("t6_rst_color", int'(color_out), 0);
        chk("t6_rst_wr_ready", int'(wr_ready), 0);
        chk("t6_rst_line_ready", int'(line_ready), 0);
        chk("t6_rst_ucnt", int'(underrun_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        ck_rst = 1'b1;
        #0.1;
        chk("t6_rel_wr_ready", int'(wr_ready), 1);
        @(negedge clk);
        pulse_nl();
        chk("t6_underrun", int'(underrun), 1);
        chk("t6_ucnt1", int'(underrun_cnt), 1);
        for (int i = 0; i < 8; i++) pix(BG);
        idle(1);
        next_line = 1'b1;
        repeat (260) @(negedge clk);
        next_line = 1'b0;
        chk("t6_ucnt_sat", int'(underrun_cnt), 255);
        @(negedge clk);
        chk("t6_ucnt_hold", int'(underrun_cnt), 255);
        idle(3);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
